// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Combinational definitions only; no latency, no flow control.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [NUM_DIGITS-1:0] an_t;

    localparam an_t AN_OFF = '1;

    function automatic an_t an_select(input logic [1:0] idx);
        an_select = ~(an_t'(1) << idx);
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Display-side bundle: BCD load port in, segment/anode drive out.
// No latency of its own; load is never backpressured.
// master drives bcd/load, slave is the scan driver.
interface seg7_scan_if;
    import seg7_pkg::*;

    logic [15:0] bcd;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    an_t         an;
    logic        frame_tick;

    modport master (
        output bcd, load,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  bcd, load,
        output seg, dp, an, frame_tick
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Nibble to active-low seven-segment pattern; non-decimal nibbles show a dash.
// Purely combinational, zero latency.
// No flow control.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-seg driver; loads defer to the frame boundary (optional SEG7_LZB_EN blanks leading zeros).
// Outputs registered: one cycle behind cnt/idx/disp; load-to-display 1..4*DIGIT_CYCLES cycles.
// No backpressure: load is always accepted, the last load before a boundary wins.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  disp_if
);

    localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   disp_q, disp_d;
    logic          pending_q, pending_d;
    logic [6:0]    seg_q, seg_d;
    an_t           an_q, an_d;
    logic          frame_tick_q, frame_tick_d;

    logic          slot_end;
    logic          boundary;
    logic          blank;
    logic          lead_zero;
    logic [3:0]    nib;
    logic [6:0]    dec_seg;

    assign nib = disp_q[{idx_q, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

`ifdef SEG7_LZB_EN
    // Blank when this digit and everything above it is zero; digit 0 always shows.
    assign lead_zero = (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'h0000);
`else
    assign lead_zero = 1'b0;
`endif

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        boundary = slot_end && (idx_q == 2'd3);
        blank    = (cnt_q < BLANK_C);

        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
        shadow_d  = disp_if.load ? disp_if.bcd : shadow_q;
        pending_d = pending_q;
        disp_d    = disp_q;

        if (boundary) begin
            // A load landing on the boundary bypasses the shadow entirely.
            pending_d = 1'b0;
            if (disp_if.load) begin
                disp_d = disp_if.bcd;
            end else if (pending_q) begin
                disp_d = shadow_q;
            end
        end else if (disp_if.load) begin
            pending_d = 1'b1;
        end

        an_d         = blank ? AN_OFF : an_select(idx_q);
        seg_d        = (blank || lead_zero) ? SEG_BLANK : dec_seg;
        frame_tick_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= 16'h0000;
            disp_q       <= 16'h0000;
            pending_q    <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign disp_if.seg        = seg_q;
    assign disp_if.an         = an_q;
    assign disp_if.frame_tick = frame_tick_q;
    assign disp_if.dp         = 1'b1;

endmodule
